// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg -- shared definitions for the multicycle Booth multiplier.
//
// Contents:
//   MULT_WIDTH     default operand width (product is 2*MULT_WIDTH)
//   MULT_STEPS     Booth iterations per multiply (one per operand bit)
//   cnt_width()    width of the step counter for a given step count
//   mult_state_e   controller states IDLE / RUN / DONE
//   booth_op_e     action chosen by one radix-2 Booth iteration
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = MULT_WIDTH;

  // One spare bit above $clog2 so the counter can hold the step count itself.
  function automatic int cnt_width(input int steps);
    return $clog2(steps) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

endpackage : mult_pkg

// File: rtl/mult_unit_booth_step.sv
// ---------------------------------------------------------------------------
// booth_step -- one combinational radix-2 Booth iteration.
//
// Looks at {q[0], q_m1}, adds or subtracts the multiplicand into the
// WIDTH+1-bit accumulator, then arithmetic-shifts {acc, q, q_m1} right by one.
//
// Ports:
//   acc        in  WIDTH+1  partial-product accumulator (two's complement)
//   q          in  WIDTH    multiplier / low product bits
//   q_m1       in  1        bit shifted out of q on the previous iteration
//   m          in  WIDTH+1  sign-extended multiplicand
//   acc_next   out WIDTH+1  accumulator after add/sub and shift
//   q_next     out WIDTH    q after shift
//   q_m1_next  out 1        new q_m1 (old q[0])
// ---------------------------------------------------------------------------
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  booth_op_e        op;
  logic [WIDTH:0]   sum;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    op  = BOOTH_NOP;
    sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    case (op)
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
  end

  // Arithmetic right shift of the {sum, q, q_m1} chain: sign bit replicated
  // at the top, the LSB of sum moves into q, q[0] becomes the new q_m1.
  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule : booth_step

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit -- multicycle signed WIDTH x WIDTH multiplier (MULT instruction).
//
// Responder side of the control unit's mult_control / mult_end handshake.
// A start in IDLE captures A and B; WIDTH radix-2 Booth iterations follow,
// one per clock; the 2*WIDTH product lands on HI/LO and mult_end pulses for
// one cycle. mult_control is ignored outside IDLE.
//
// Build option:
//   MULT_ZERO_BYPASS_EN  when defined, a start with A==0 or B==0 skips the
//                        Booth iterations and goes straight to DONE with
//                        HI=LO=0.
//
// Ports:
//   clk           in   1      system clock, rising edge
//   reset         in   1      synchronous, active-high
//   mult_control  in   1      start request, sampled only in IDLE
//   A             in   WIDTH  multiplicand, two's complement
//   B             in   WIDTH  multiplier, two's complement
//   HI            out  WIDTH  upper half of the last product
//   LO            out  WIDTH  lower half of the last product
//   mult_end      out  1      one-cycle done pulse; HI/LO valid while high
//   busy          out  1      high from accepted start until back in IDLE
// ---------------------------------------------------------------------------
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             mult_end,
  output logic             busy
);

  localparam int               CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_e state, state_next;

  // Working registers. acc is one bit wider than the operands so that
  // subtracting M = -2^(WIDTH-1) cannot overflow the accumulator.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [CNT_W-1:0] step_cnt;

  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             q_m1_next;

  logic             zero_op;
  logic             last_step;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (A == '0) || (B == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_step = (state == ST_RUN) && (step_cnt == LAST_STEP);

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .m         (m),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // ---------------------------------------------------------------- FSM ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mult_control) state_next = zero_op ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step)    state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath ----
  // NOTE: the working registers are reset alongside HI/LO even though every
  // start reloads them; this keeps them out of X after reset and costs only
  // a synchronous clear on plain flops (there is no memory array here).
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      m        <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      step_cnt <= '0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mult_control) begin
            m        <= {A[WIDTH-1], A};
            q        <= B;
            q_m1     <= 1'b0;
            acc      <= '0;
            step_cnt <= '0;
            if (zero_op) begin
              HI <= '0;
              LO <= '0;
            end
          end
        end
        ST_RUN: begin
          acc      <= acc_next;
          q        <= q_next;
          q_m1     <= q_m1_next;
          step_cnt <= step_cnt + CNT_W'(1);
          // The final iteration's result goes straight to HI/LO so the
          // product is visible in the same cycle mult_end rises.
          if (last_step) begin
            HI <= acc_next[WIDTH-1:0];
            LO <= q_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_end = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

endmodule : mult_unit
